// File: rtl/btn_pkg.sv
// Shared button/command definitions used by the debouncer, this queue and the game FSM.
package btn_pkg;

  localparam int DEFAULT_N_BUTTONS = 3;

  localparam logic [DEFAULT_N_BUTTONS-1:0] BTN_IDLE = '1;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'd0,
    CMD_RIGHT = 2'd1,
    CMD_DROP  = 2'd2
  } cmd_e;

  typedef enum logic [1:0] {
    EV_IDLE,
    EV_SINGLE,
    EV_CHORD
  } btn_event_e;

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the slot on the same edge.
module cmd_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are unreachable
  // because level gates the read and pop_data is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // When full with a pop, wr_ptr == rd_ptr: the head is read out before the
  // edge and the new entry lands in the slot being vacated.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/btn_cmd_queue.sv
// Classifies active-low press pulses into command codes, queues them for the
// game FSM over valid/ready, and keeps sticky overflow/chord error flags.
module btn_cmd_queue
  import btn_pkg::*;
#(
  parameter int N_BUTTONS = DEFAULT_N_BUTTONS,
  parameter int DEPTH     = 4,
  parameter int CODE_W    = $clog2(N_BUTTONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BUTTONS-1:0]     btns_in,
  input  logic                     cmd_ready,
  input  logic                     clr_err,
  output logic                     cmd_valid,
  output logic [CODE_W-1:0]        cmd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_overflow,
  output logic                     err_chord
);

  btn_event_e          ev;
  logic [CODE_W-1:0]   press_code;
  logic                push_req, pop, full, empty, overflow_evt;
  logic                err_overflow_q, err_overflow_d;
  logic                err_chord_q, err_chord_d;

  always_comb begin
    int n_low;
    n_low      = 0;
    press_code = '0;
    ev         = EV_IDLE;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (!btns_in[i]) begin
        n_low++;
        press_code = CODE_W'(i);
      end
    end
    if (n_low == 1)     ev = EV_SINGLE;
    else if (n_low > 1) ev = EV_CHORD;
  end

  assign push_req     = (ev == EV_SINGLE);
  assign pop          = cmd_valid & cmd_ready;
  assign overflow_evt = push_req & full & ~pop;

  cmd_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (press_code),
    .pop       (pop),
    .pop_data  (cmd_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign cmd_valid = ~empty;

  // Set takes priority over clear when both land on the same edge.
  always_comb begin
    err_overflow_d = (err_overflow_q & ~clr_err) | overflow_evt;
    err_chord_d    = (err_chord_q    & ~clr_err) | (ev == EV_CHORD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_q <= 1'b0;
      err_chord_q    <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_chord_q    <= err_chord_d;
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_chord    = err_chord_q;

endmodule
